// File: rtl/sim_pkg.sv
`default_nettype none
// sim_pkg: shared config-word layout, azimuth width and FSM encoding for the target scheduler (rev 1.0).
package sim_pkg;

  localparam int AZ_W              = 10;
  localparam int CNT_W             = 13;
  localparam int CFG_W             = 14;
  localparam int CFG_START_LSB     = 0;
  localparam int CFG_FAST_SLOW_BIT = 10;
  localparam int CFG_MOTION_BIT    = 11;
  localparam int CFG_INWARD_BIT    = 12;
  localparam int CFG_ENABLE_BIT    = 13;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic            enable;
    logic            inward;
    logic            moving;
    logic            slow;
    logic [AZ_W-1:0] start;
  } slot_cfg_t;

  function automatic slot_cfg_t unpack_cfg(input logic [CFG_W-1:0] word);
    slot_cfg_t c;
    c.enable = word[CFG_ENABLE_BIT];
    c.inward = word[CFG_INWARD_BIT];
    c.moving = word[CFG_MOTION_BIT];
    c.slow   = word[CFG_FAST_SLOW_BIT];
    c.start  = word[CFG_START_LSB +: AZ_W];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_target_slot.sv
`default_nettype none
// sim_target_slot: one target slot -- config, revolution counter, drifting offset, position and compare (rev 1.0).
module sim_target_slot
  import sim_pkg::*;
#(
  parameter int FAST_SH = 10,
  parameter int SLOW_SH = 12
) (
  input  logic            clk,
  input  logic            resset,
  input  logic [AZ_W-1:0] range,
  input  logic            wr_en,
  input  slot_cfg_t       wr_cfg,
  input  logic            upd_en,
  output logic            hit,
  output logic            ref_hit
);

  localparam logic [CNT_W-1:0] FAST_MASK = CNT_W'((1 << FAST_SH) - 1);
  localparam logic [CNT_W-1:0] SLOW_MASK = CNT_W'((1 << SLOW_SH) - 1);

  slot_cfg_t        cfg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [AZ_W-1:0]  offset;
  logic [AZ_W-1:0]  offset_nxt;
  logic [AZ_W-1:0]  pos;
  logic             roll;

  // The offset steps when the low bits of the incremented count wrap to zero.
  always_comb begin
    cnt_inc    = cnt + CNT_W'(1);
    roll       = ((cnt_inc & (cfg.slow ? SLOW_MASK : FAST_MASK)) == '0);
    offset_nxt = roll ? offset + AZ_W'(1) : offset;
  end

  always_ff @(posedge clk) begin
    if (!resset) begin
      cfg    <= '0;
      cnt    <= '0;
      offset <= '0;
      pos    <= '0;
    end else if (wr_en) begin
      cfg    <= wr_cfg;
      cnt    <= '0;
      offset <= '0;
      pos    <= wr_cfg.start;
    end else if (upd_en && cfg.enable) begin
      if (cfg.moving) begin
        cnt    <= cnt_inc;
        offset <= offset_nxt;
        pos    <= cfg.inward ? cfg.start + offset_nxt : cfg.start - offset_nxt;
      end else begin
        cnt    <= '0;
        offset <= '0;
        pos    <= cfg.start;
      end
    end
  end

  assign hit     = cfg.enable && (range == pos);
  assign ref_hit = cfg.enable && (range == cfg.start);

endmodule
`default_nettype wire

// File: rtl/sim_target_sched.sv
`default_nettype none
// sim_target_sched: revolution-driven scheduler that walks NSLOT target slots and reports registered hits (rev 1.0).
module sim_target_sched
  import sim_pkg::*;
#(
  parameter int NSLOT   = 4,
  parameter int FAST_SH = 10,
  parameter int SLOW_SH = 12
) (
  input  logic             clk,
  input  logic             resset,
  input  logic [AZ_W-1:0]  range,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ack,
  output logic             target_range,
  output logic             target_ref,
  output logic [2:0]       hit_id,
  output logic             rev_pulse
);

  sched_state_t    state;
  logic [AZ_W-1:0] range_q;
  logic [2:0]      upd_idx;
  logic            rev;
  logic            accept;
  slot_cfg_t       wr_cfg;
  logic [NSLOT-1:0] hits;
  logic [NSLOT-1:0] refs;
  logic [2:0]      first_hit;

  assign rev    = (range_q > range);
  // The requester holds cfg_we through the ack cycle, so that cycle must not re-accept.
  assign accept = (state == ST_IDLE) && !rev && cfg_we && !cfg_ack;
  assign wr_cfg = unpack_cfg(cfg_data);

  generate
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      sim_target_slot #(
        .FAST_SH (FAST_SH),
        .SLOW_SH (SLOW_SH)
      ) u_slot (
        .clk     (clk),
        .resset  (resset),
        .range   (range),
        .wr_en   (accept && (cfg_addr == 3'(i))),
        .wr_cfg  (wr_cfg),
        .upd_en  ((state == ST_UPDATE) && (upd_idx == 3'(i))),
        .hit     (hits[i]),
        .ref_hit (refs[i])
      );
    end
  endgenerate

  always_comb begin
    first_hit = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (hits[i]) first_hit = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resset) begin
      state        <= ST_IDLE;
      range_q      <= '0;
      upd_idx      <= '0;
      cfg_ack      <= 1'b0;
      target_range <= 1'b0;
      target_ref   <= 1'b0;
      hit_id       <= '0;
      rev_pulse    <= 1'b0;
    end else begin
      range_q      <= range;
      rev_pulse    <= rev;
      cfg_ack      <= accept;
      target_range <= |hits;
      target_ref   <= |refs;
      hit_id       <= first_hit;
      case (state)
        ST_IDLE: begin
          if (rev) begin
            state   <= ST_UPDATE;
            upd_idx <= '0;
          end
        end
        ST_UPDATE: begin
          if (upd_idx == 3'(NSLOT - 1)) state <= ST_IDLE;
          else                          upd_idx <= upd_idx + 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_target_sched.sv
`default_nettype none
// tb_sim_target_sched: directed self-checking bench for the target scheduler.
module tb_sim_target_sched;

  localparam int NSLOT = 4;
  localparam logic [13:0] EN  = 14'h2000;
  localparam logic [13:0] MOV = 14'h0800;

  logic        clk = 1'b0;
  logic        resset = 1'b0;
  logic [9:0]  range = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [13:0] cfg_data = '0;
  logic        cfg_ack;
  logic        target_range;
  logic        target_ref;
  logic [2:0]  hit_id;
  logic        rev_pulse;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sim_target_sched #(
    .NSLOT   (NSLOT),
    .FAST_SH (1),
    .SLOW_SH (12)
  ) dut (
    .clk          (clk),
    .resset       (resset),
    .range        (range),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ack      (cfg_ack),
    .target_range (target_range),
    .target_ref   (target_ref),
    .hit_id       (hit_id),
    .rev_pulse    (rev_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(cfg_ack), 0);
    chk({tag, "_trange"}, 32'(target_range), 0);
    chk({tag, "_tref"}, 32'(target_ref), 0);
    chk({tag, "_hitid"}, 32'(hit_id), 0);
    chk({tag, "_rev"}, 32'(rev_pulse), 0);
  endtask

  task automatic probe(input logic [9:0] r, input logic tr, input logic tf,
                       input logic [2:0] id, input string tag);
    range = r;
    step();
    chk({tag, "_trange"}, 32'(target_range), 32'(tr));
    chk({tag, "_tref"}, 32'(target_ref), 32'(tf));
    chk({tag, "_hitid"}, 32'(hit_id), 32'(id));
  endtask

  task automatic revolution();
    range = 10'd1023;
    step();
    range = 10'd0;
    step();
    chk("rev_pulse", 32'(rev_pulse), 1);
    repeat (NSLOT + 1) step();
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [13:0] data);
    cfg_addr = addr;
    cfg_data = data;
    cfg_we   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (cfg_ack) break;
    end
    chk("cfg_ack", 32'(cfg_ack), 1);
    cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    resset = 1'b0;
    range  = 10'd0;
    step();
    step();
    chk_all_zero("reset");
    resset = 1'b1;
    step();

    // Static slot 0 at 100
    cfg_write(3'd0, EN | 14'd100);
    probe(10'd99,  1'b0, 1'b0, 3'd0, "s0_99");
    probe(10'd100, 1'b1, 1'b1, 3'd0, "s0_100");
    probe(10'd101, 1'b0, 1'b0, 3'd0, "s0_101");
    revolution();
    probe(10'd100, 1'b1, 1'b1, 3'd0, "s0_rev1");
    revolution();

    // Slot 1 moving outward fast from 5
    cfg_write(3'd1, EN | MOV | 14'd5);
    probe(10'd5,   1'b1, 1'b1, 3'd1, "s1_start");
    probe(10'd100, 1'b1, 1'b1, 3'd0, "s0_still");
    revolution();
    probe(10'd5,   1'b1, 1'b1, 3'd1, "s1_rev1");
    revolution();
    probe(10'd4,   1'b1, 1'b0, 3'd1, "s1_pos4");
    probe(10'd5,   1'b0, 1'b1, 3'd0, "s1_ref5");
    repeat (10) revolution();
    probe(10'd1022, 1'b0, 1'b0, 3'd0, "s1_1022");
    probe(10'd1023, 1'b1, 1'b0, 3'd1, "s1_wrap");
    revolution();

    // Two slots on the same start: lowest index wins
    cfg_write(3'd1, 14'd0);
    cfg_write(3'd0, EN | 14'd300);
    cfg_write(3'd2, EN | 14'd300);
    probe(10'd300, 1'b1, 1'b1, 3'd0, "both300");
    cfg_write(3'd0, 14'd300);
    probe(10'd300, 1'b1, 1'b1, 3'd2, "s2_only");

    // Out-of-range address is acknowledged but changes nothing
    cfg_write(3'd7, EN | 14'd400);
    probe(10'd400, 1'b0, 1'b0, 3'd0, "addr7");

    // Write coinciding with the wrap: revolution first, ack NSLOT+1 cycles later
    range = 10'd1023;
    step();
    range    = 10'd0;
    cfg_addr = 3'd3;
    cfg_data = EN | 14'd50;
    cfg_we   = 1'b1;
    step();
    chk("wrap_rev", 32'(rev_pulse), 1);
    chk("wrap_ack_early", 32'(cfg_ack), 0);
    n = 0;
    while (!cfg_ack && n < 20) begin
      step();
      n++;
    end
    chk("ack_latency", 32'(n), 32'(NSLOT + 1));
    cfg_we = 1'b0;
    probe(10'd50, 1'b1, 1'b1, 3'd3, "s3_hit");

    // Reset in the middle of UPDATE
    range = 10'd1023;
    step();
    range = 10'd0;
    step();
    chk("upd_rev", 32'(rev_pulse), 1);
    step();
    resset = 1'b0;
    step();
    chk_all_zero("mid_rst");
    resset = 1'b1;
    step();
    probe(10'd50,  1'b0, 1'b0, 3'd0, "post_rst_50");
    probe(10'd300, 1'b0, 1'b0, 3'd0, "post_rst_300");
    cfg_write(3'd0, EN | 14'd400);
    probe(10'd400, 1'b1, 1'b1, 3'd0, "reconf");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_target_sched.md
SIM_TARGET_SCHED -- requirements
Module: sim_target_sched

Interface
REQ-001 SHALL have parameter NSLOT, default 4, number of target slots (2..8).
REQ-002 SHALL have parameter FAST_SH, default 10, log2 of revolutions per offset step in fast mode.
REQ-003 SHALL have parameter SLOW_SH, default 12, log2 of revolutions per offset step in slow mode.
REQ-004 SHALL have port clk  input  1  system clock. One clock; all logic rising-edge.
REQ-005 SHALL have port resset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port range  input  10  azimuth code, free-running 0..1023.
REQ-007 SHALL have port cfg_we  input  1  configuration write request, held until cfg_ack.
REQ-008 SHALL have port cfg_addr  input  3  slot index; values >= NSLOT are ignored but still acknowledged.
REQ-009 SHALL have port cfg_data  input  14  config word: [9:0] start, [10] fast_slow (0 fast), [11] static_motion (1 moving), [12] inward_outward (1 inward), [13] enable.
REQ-010 SHALL have port cfg_ack  output  1  single-cycle write acknowledge.
REQ-011 SHALL have port target_range  output  1  OR of all enabled slot hits.
REQ-012 SHALL have port target_ref  output  1  OR of all enabled slots' static start hits.
REQ-013 SHALL have port hit_id  output  3  lowest-index slot currently hitting; 0 when none.
REQ-014 SHALL have port rev_pulse  output  1  one-cycle pulse per detected revolution.

Function
REQ-015 SHALL register range each cycle; revolution detected when registered range > current range (wrap 1023->0 or any decrease).
REQ-016 SHALL hold a per-slot 13-bit revolution counter incremented on each revolution while slot enabled and moving.
REQ-017 SHALL step a slot's 10-bit offset when its counter low FAST_SH bits (fast) or SLOW_SH bits (slow) roll over to zero.
REQ-018 SHALL compute position = start + offset (inward) or start - offset (outward), modulo 1024; wrap past 0/1023 is correct, not saturated.
REQ-019 SHALL force offset to 0 when static_motion = 0.
REQ-020 SHALL use FSM IDLE -> UPDATE -> IDLE; IDLE->UPDATE on revolution; UPDATE visits slot 0..NSLOT-1 one per cycle, then returns to IDLE.
REQ-021 SHALL service cfg_we only in IDLE; cfg_ack one cycle after acceptance; a write during UPDATE stalls until IDLE.
REQ-022 SHALL reset the written slot's counter and offset to 0 on every accepted config write.
REQ-023 SHALL give revolution priority if cfg_we and revolution coincide in IDLE; the write is accepted after UPDATE.
REQ-024 SHALL drive target_range/target_ref/hit_id registered, one cycle after range matches position/start.
REQ-025 SHALL ignore disabled slots for all outputs and counting.
REQ-026 SHALL update positions only in UPDATE; comparisons use last committed positions.

Reset
REQ-027 SHALL, with resset low at a clk edge, clear all slot configs (enable = 0), counters, offsets, positions, FSM to IDLE.
REQ-028 SHALL drive cfg_ack, target_range, target_ref, rev_pulse 0 and hit_id 0 during and after reset.
REQ-029 SHALL abandon an in-progress UPDATE or pending write on reset mid-operation; no partial state survives.

Structure
REQ-030 SHALL place the cfg_data field offsets, FSM state encoding and azimuth width (10) in a shared package sim_pkg.
REQ-031 SHALL implement one slot (config, counter, offset, position, compare) as sub-module sim_target_slot, instantiated NSLOT times.

Verification
REQ-032 SHALL cover: slot 0 start=100 static enabled, range sweeps -> target_range and target_ref pulse at range 100, hit_id=0, every revolution.
REQ-033 SHALL cover: slot 1 start=5 moving outward fast, FAST_SH=1 -> hit at 5, then 4 after 2 revolutions, reaching 1023 after 12 revolutions (wrap).
REQ-034 SHALL cover: slots 0 and 2 both start=300 -> hit_id=0; disable slot 0 -> hit_id=2.
REQ-035 SHALL cover: cfg_we asserted on wrap cycle -> rev_pulse first, cfg_ack exactly NSLOT+1 cycles later.
REQ-036 SHALL cover: resset low during UPDATE -> all outputs 0 next cycle, no hits until reconfigured.
REQ-037 SHALL cover: cfg_addr=7 with NSLOT=4 -> cfg_ack pulses, no slot state changes.
